cas_lock_seq: RTL
=================

# cas_lock_seq

Sequential, parametrised CAS-Lock key-gating unit for the locked-benchmark flow. It takes an N_IN-bit primary-input vector and the original circuit's output bit, evaluates two key-XORed cascaded AND/OR chains, and flips the output bit when the key is wrong. The secret key is loaded serially through a key port rather than presented in parallel. The block adds a 2-cycle registered pipeline, a locked-until-loaded policy, and a saturating flip counter, so attack benches can measure corruption rate.

## Interface
Parameters:
- N_IN, default 32: chain length; the key width is 2*N_IN.
- CHAIN_PATTERN, default 32'h0000_7E00: per-stage gate type for stages 1..N_IN-1. A bit value of 1 selects OR and 0 selects AND. Bit 0 is ignored.
- CNT_W, default 16: width of the flip counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- key_start  in  1  single-cycle pulse; clears the key shift register and key_loaded.
- key_bit_valid  in  1  shifts key_bit in on this cycle.
- key_bit  in  1  key data, MSB first (key[2*N_IN-1] arrives first).
- key_loaded  out  1  high once 2*N_IN bits have been shifted in since the last key_start or reset.
- in_valid  in  1  qualifies in_data and in_y.
- in_data  in  N_IN  primary inputs feeding both chains.
- in_y  in  1  output bit of the original, unlocked circuit.
- out_valid  out  1  in_valid delayed by 2 cycles.
- out_y  out  1  in_y XOR flip.
- out_flip  out  1  the flip value applied to this sample.
- flip_count  out  CNT_W  number of valid samples with flip=1; saturates at the maximum value.

## Operation
- Chain function, for key half k (k = key[N_IN-1:0] for chain A, k = key[2*N_IN-1:N_IN] for chain B):
  - x_i = in_data[i] ^ k[i]
  - g_0 = x_0
  - g_i = CHAIN_PATTERN[i] ? (x_i | g_{i-1}) : (x_i & g_{i-1})
  - The chain output is g_{N_IN-1}.
- Flip rule: flip = gA & ~gB.
  - A key whose two halves are equal gives flip = 0 for every input.
  - When key_loaded = 0, flip is forced to 1 for every sample.
- Key loader:
  - Shift register: key <= {key[2*N_IN-2:0], key_bit} on each key_bit_valid cycle.
  - A 0..2*N_IN bit counter tracks loaded bits. key_loaded rises when the counter reaches 2*N_IN.
  - Extra bits beyond 2*N_IN keep shifting in, and key_loaded stays 1.
  - If key_start and key_bit_valid occur in the same cycle, key_start wins and the bit is discarded.
- Flip counter increments on each out_valid cycle with out_flip = 1. It holds at 2^CNT_W-1 once saturated.
- Reset values:
  - key register = 0
  - bit counter = 0
  - key_loaded = 0
  - out_valid = 0
  - out_y = 0
  - out_flip = 0
  - flip_count = 0
  - All pipeline valid bits = 0.

## Timing
- Stage 1 (cycle T+1): registers in_valid, in_y, and both x vectors. The x vectors use the key value present at cycle T.
- Stage 2 (cycle T+2): registers out_valid, out_y, out_flip, and the key_loaded-forced flag sampled at cycle T. The counter updates in the same cycle.
- Throughput is one sample per cycle. There is no backpressure.
- A key change or key_start while samples are in flight does not alter those samples. Each sample uses the key and key_loaded state captured at its own input cycle.
- key_loaded goes high in the cycle after the 2*N_IN-th key_bit_valid.
- Asserting rst mid-stream clears both pipeline stages. No out_valid is produced for samples already in flight.

## Structure
- Package cas_lock_pkg holds:
  - a chain_eval(x, pattern) function;
  - the default CHAIN_PATTERN constant;
  - a typedef for the loader bit-count width, $clog2(2*N_IN+1).
- Sub-module cas_chain: a purely combinational N_IN-stage chain, parametrised by N_IN and CHAIN_PATTERN, instantiated twice (chain A and chain B).
- The key loader, pipeline and counter live in the top module.

## Test plan
All scenarios use N_IN=4 and CHAIN_PATTERN=4'b0100 (g1=AND, g2=OR, g3=AND).
- Reset then stream without loading a key: in_data=4'hF, in_y=0 for 3 cycles -> out_valid at +2, out_flip=1, out_y=1, flip_count=3.
- Load key 8'h00 (8 serial bits), then in_data=4'hF, in_y=1 -> gA=gB=1, flip=0, out_y=1 at +2, flip_count unchanged. key_loaded rises 1 cycle after the 8th bit.
- Load key 8'hF0 (B=1111, A=0000), then in_data=4'hF, in_y=0 -> gA=1, gB=0, out_flip=1, out_y=1, flip_count increments.
- Start a new key load while two samples are in flight -> those samples keep the old-key results. The following samples show forced flip=1 until 8 new bits have arrived.
- key_start and key_bit_valid in the same cycle -> bit counter=0 and key=0 afterwards.
- CNT_W=2 with 5 forced-flip samples -> flip_count=3 and holds there; rst mid-stream -> out_valid=0 for the next 2 cycles and flip_count=0.

Source files
------------

// File: rtl/cas_lock_pkg.sv
// -----------------------------------------------------------------------------
// cas_lock_pkg
// Shared definitions for the CAS-Lock key-gating unit.
//   MAX_N                 : widest chain the helpers are sized for
//   DEFAULT_CHAIN_PATTERN : default per-stage gate selection (1 = OR, 0 = AND)
//   key_cnt_t             : loader bit counter, wide enough to hold 0..2*MAX_N
//   chain_eval()          : reference evaluation of one cascaded AND/OR chain
// -----------------------------------------------------------------------------
package cas_lock_pkg;

    localparam int MAX_N = 64;

    localparam logic [31:0] DEFAULT_CHAIN_PATTERN = 32'h0000_7E00;

    // Sized for the widest chain so that every legal N_IN can count up to
    // 2*N_IN without overflowing.
    typedef logic [$clog2(2*MAX_N+1)-1:0] key_cnt_t;

    // Walks the chain from stage 0 upward. Stage 0 just passes x[0]; every
    // later stage combines its own x bit with the running result using the
    // gate chosen by the matching pattern bit. Stages at or beyond n are
    // skipped so narrower chains can share this helper.
    function automatic logic chain_eval(input logic [MAX_N-1:0] x,
                                        input logic [MAX_N-1:0] pattern,
                                        input int n);
        logic g;
        g = x[0];
        for (int i = 1; i < MAX_N; i++) begin
            if (i < n) begin
                g = pattern[i] ? (x[i] | g) : (x[i] & g);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/cas_chain.sv
// -----------------------------------------------------------------------------
// cas_chain
// Purely combinational N_IN-stage cascaded AND/OR chain.
// Ports:
//   x : N_IN-bit key-XORed input vector
//   g : chain output (last stage)
// -----------------------------------------------------------------------------
module cas_chain
    import cas_lock_pkg::*;
#(
    parameter int               N_IN          = 32,
    parameter logic [N_IN-1:0]  CHAIN_PATTERN = N_IN'(DEFAULT_CHAIN_PATTERN)
) (
    input  logic [N_IN-1:0] x,
    output logic            g
);

    assign g = chain_eval(MAX_N'(x), MAX_N'(CHAIN_PATTERN), N_IN);

endmodule

// File: rtl/cas_lock_seq.sv
// -----------------------------------------------------------------------------
// cas_lock_seq
// Sequential CAS-Lock key-gating unit with a serial key loader, a two-stage
// registered pipeline and a saturating flip counter.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   key_start     : clears the key register and the loaded state
//   key_bit_valid : shifts key_bit in (MSB of the key first)
//   key_bit       : serial key data
//   key_loaded    : all 2*N_IN key bits received since the last clear
//   in_valid      : qualifies in_data / in_y
//   in_data       : primary inputs feeding both chains
//   in_y          : original circuit output bit
//   out_valid     : in_valid delayed by two cycles
//   out_y         : in_y XOR flip
//   out_flip      : flip applied to this sample
//   flip_count    : saturating count of output samples with flip = 1
// -----------------------------------------------------------------------------
module cas_lock_seq
    import cas_lock_pkg::*;
#(
    parameter int               N_IN          = 32,
    parameter logic [N_IN-1:0]  CHAIN_PATTERN = N_IN'(DEFAULT_CHAIN_PATTERN),
    parameter int               CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit_valid,
    input  logic             key_bit,
    output logic             key_loaded,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    input  logic             in_y,
    output logic             out_valid,
    output logic             out_y,
    output logic             out_flip,
    output logic [CNT_W-1:0] flip_count
);

    localparam int       KEY_W    = 2 * N_IN;
    localparam key_cnt_t KEY_BITS = key_cnt_t'(KEY_W);

    logic [KEY_W-1:0] key_reg;
    key_cnt_t         bit_cnt;

    logic             s1_valid;
    logic             s1_y;
    logic             s1_forced;
    logic [N_IN-1:0]  s1_xa;
    logic [N_IN-1:0]  s1_xb;

    logic             ga;
    logic             gb;
    logic             flip;

    // Serial key loader. key_start takes priority over a bit arriving in the
    // same cycle, so that bit is dropped. The counter stops at 2*N_IN while
    // extra bits keep shifting through the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
            bit_cnt <= '0;
        end else if (key_start) begin
            key_reg <= '0;
            bit_cnt <= '0;
        end else if (key_bit_valid) begin
            key_reg <= {key_reg[KEY_W-2:0], key_bit};
            if (bit_cnt != KEY_BITS) begin
                bit_cnt <= bit_cnt + key_cnt_t'(1);
            end
        end
    end

    assign key_loaded = (bit_cnt == KEY_BITS);

    // Stage 1 captures the key-XORed vectors and the not-yet-loaded flag
    // together with the sample, so a later key change or key_start cannot
    // reach back into samples already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_y      <= 1'b0;
            s1_forced <= 1'b0;
            s1_xa     <= '0;
            s1_xb     <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_y      <= in_y;
            s1_forced <= ~key_loaded;
            s1_xa     <= in_data ^ key_reg[N_IN-1:0];
            s1_xb     <= in_data ^ key_reg[KEY_W-1:N_IN];
        end
    end

    cas_chain #(
        .N_IN          (N_IN),
        .CHAIN_PATTERN (CHAIN_PATTERN)
    ) u_chain_a (
        .x (s1_xa),
        .g (ga)
    );

    cas_chain #(
        .N_IN          (N_IN),
        .CHAIN_PATTERN (CHAIN_PATTERN)
    ) u_chain_b (
        .x (s1_xb),
        .g (gb)
    );

    // Equal key halves make the two chains agree, so ga & ~gb is 0 for
    // the correct key; an unloaded key corrupts every sample.
    assign flip = s1_forced | (ga & ~gb);

    // Stage 2 registers the outputs and counts corrupted samples, holding
    // the counter at all-ones once it saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_y      <= 1'b0;
            out_flip   <= 1'b0;
            flip_count <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_y    <= s1_y ^ flip;
                out_flip <= flip;
                if (flip && (flip_count != {CNT_W{1'b1}})) begin
                    flip_count <= flip_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
